// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit and the main decoder.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } md_state_e;

  // Cycles from the accepting edge to the edge that writes HI/LO.
  localparam int MD_LATENCY = 33;

  function automatic logic md_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Decoder helper: R-type funct field to unit opcode.
  function automatic md_op_e md_op_from_funct(input logic [5:0] funct);
    md_op_e op;
    case (funct)
      6'b011000: op = MD_MULT;
      6'b011001: op = MD_MULTU;
      6'b011010: op = MD_DIV;
      6'b011011: op = MD_DIVU;
      default:   op = MD_MULT;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix.
module muldiv_negate #(
  parameter int WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  assign dout = en ? (~din + {{(WIDTH-1){1'b0}}, 1'b1}) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Multicycle HI/LO multiply/divide unit: one shift-add or restoring-divide step per cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_req,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  md_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  md_op_e             op_q, op_d;
  logic               sign_q, sign_d;        // quotient / product negate
  logic               rsign_q, rsign_d;      // remainder negate (dividend sign)
  logic               zero_div_q, zero_div_d;
  logic [WIDTH-1:0]   a_orig_q, a_orig_d;    // raw dividend, returned as HI on divide by zero
  logic [WIDTH-1:0]   mag_a_q, mag_a_d;      // multiplicand magnitude
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;      // divisor, or the right-shifting multiplier
  logic [2*WIDTH-1:0] acc_q, acc_d;          // product, or {remainder, quotient}
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d;

  md_op_e             op_in_s;
  logic               accept_s;
  logic               in_signed_s;
  logic [WIDTH-1:0]   abs_a_s, abs_b_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]   quot_fix_s, rem_fix_s;
  logic [WIDTH-1:0]   addend_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     srem_s;
  logic [WIDTH+1:0]   trial_s;
  logic               trial_ok_s;

  assign op_in_s     = md_op_e'(op);
  assign in_signed_s = md_is_signed(op_in_s);
  // FIX is the retiring cycle, so a re-presented start can be taken there as well.
  assign accept_s    = start & ((state_q == IDLE) | (state_q == FIX));

  muldiv_negate #(.WIDTH(WIDTH)) u_neg_a (
    .en(in_signed_s & a[WIDTH-1]), .din(a), .dout(abs_a_s)
  );
  muldiv_negate #(.WIDTH(WIDTH)) u_neg_b (
    .en(in_signed_s & b[WIDTH-1]), .din(b), .dout(abs_b_s)
  );
  // sign_q / rsign_q are only ever set for signed ops.
  muldiv_negate #(.WIDTH(2*WIDTH)) u_neg_prod (
    .en(sign_q), .din(acc_q), .dout(prod_fix_s)
  );
  muldiv_negate #(.WIDTH(WIDTH)) u_neg_quot (
    .en(sign_q), .din(acc_q[WIDTH-1:0]), .dout(quot_fix_s)
  );
  muldiv_negate #(.WIDTH(WIDTH)) u_neg_rem (
    .en(rsign_q), .din(acc_q[2*WIDTH-1:WIDTH]), .dout(rem_fix_s)
  );

  // Single-step arithmetic: multiply add of the upper half, divide trial subtraction.
  always_comb begin
    if (mag_b_q[0]) begin
      addend_s = mag_a_q;
    end else begin
      addend_s = {WIDTH{1'b0}};
    end
    sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend_s};
    srem_s  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    trial_s = {1'b0, srem_s} - {2'b00, mag_b_q};
    // Remainder stays below the divisor, so a kept result never reaches bit WIDTH.
    trial_ok_s = (trial_s[WIDTH+1:WIDTH] == 2'b00);
  end

  // Next-state, datapath update and HI/LO write selection.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    sign_d     = sign_q;
    rsign_d    = rsign_q;
    zero_div_d = zero_div_q;
    a_orig_d   = a_orig_q;
    mag_a_d    = mag_a_q;
    mag_b_d    = mag_b_q;
    acc_d      = acc_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (hi_we) begin
          hi_d = wdata;
        end else begin
          hi_d = hi_q;
        end
        if (lo_we) begin
          lo_d = wdata;
        end else begin
          lo_d = lo_q;
        end
      end
      RUN: begin
        if (md_is_div(op_q)) begin
          if (trial_ok_s) begin
            acc_d = {trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {srem_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d   = {sum_s, acc_q[WIDTH-1:1]};
          mag_b_d = {1'b0, mag_b_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = {CW{1'b0}};
          state_d = FIX;
        end else begin
          cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (md_is_div(op_q) && zero_div_q) begin
          lo_d = {WIDTH{1'b1}};
          hi_d = a_orig_q;
        end else if (md_is_div(op_q)) begin
          lo_d = quot_fix_s;
          hi_d = rem_fix_s;
        end else begin
          hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
          lo_d = prod_fix_s[WIDTH-1:0];
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept_s) begin
      op_d       = op_in_s;
      sign_d     = in_signed_s & (a[WIDTH-1] ^ b[WIDTH-1]);
      rsign_d    = in_signed_s & a[WIDTH-1];
      zero_div_d = (b == {WIDTH{1'b0}});
      a_orig_d   = a;
      mag_a_d    = abs_a_s;
      mag_b_d    = abs_b_s;
      cnt_d      = {CW{1'b0}};
      state_d    = RUN;
      if (md_is_div(op_in_s)) begin
        acc_d = {{WIDTH{1'b0}}, abs_a_s};
      end else begin
        acc_d = {(2*WIDTH){1'b0}};
      end
    end else begin
      op_d = op_q;
    end

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= {CW{1'b0}};
      op_q       <= MD_MULT;
      sign_q     <= 1'b0;
      rsign_q    <= 1'b0;
      zero_div_q <= 1'b0;
      a_orig_q   <= {WIDTH{1'b0}};
      mag_a_q    <= {WIDTH{1'b0}};
      mag_b_q    <= {WIDTH{1'b0}};
      acc_q      <= {(2*WIDTH){1'b0}};
      hi_q       <= {WIDTH{1'b0}};
      lo_q       <= {WIDTH{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      sign_q     <= sign_d;
      rsign_q    <= rsign_d;
      zero_div_q <= zero_div_d;
      a_orig_q   <= a_orig_d;
      mag_a_q    <= mag_a_d;
      mag_b_q    <= mag_b_d;
      acc_q      <= acc_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign stall = busy_q & (start | rd_req | hi_we | lo_we);
  assign busy  = busy_q;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
